// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_AND    = 3'b000;
  localparam logic [OP_W-1:0] OP_OR     = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD    = 3'b010;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'b011;
  localparam logic [OP_W-1:0] OP_PASS_B = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR    = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB    = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT    = 3'b111;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: on a conflict the requester that
// did not win last time is chosen.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_id    = 1'b0;
    if (valid0 && valid1) begin
      gnt_id = ~last_grant;
    end else if (valid1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared combinational ALU.
// Optional grant statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_co,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_co,
  output logic              rsp_zero,
  output logic              rsp_ovf
);

  state_t state_reg, state_next;
  logic   last_grant_reg;
  logic   id_reg;
  logic   gnt_valid, gnt_id;
  logic   accept;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_reg),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Readies depend only on state and the valids, never on rsp_ready.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          accept     = 1'b1;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state_reg == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ctr        <= '0;
      rsp_id         <= 1'b0;
      rsp_res        <= '0;
      rsp_co         <= 1'b0;
      rsp_zero       <= 1'b0;
      rsp_ovf        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_a          <= gnt_id ? req1_a  : req0_a;
        alu_b          <= gnt_id ? req1_b  : req0_b;
        alu_ctr        <= gnt_id ? req1_op : req0_op;
        id_reg         <= gnt_id;
        last_grant_reg <= gnt_id;
      end
      // The ALU has had the whole EXEC cycle to settle on the registered operands.
      if (state_reg == EXEC) begin
        rsp_res  <= alu_res;
        rsp_co   <= alu_co;
        rsp_zero <= alu_zero;
        rsp_ovf  <= alu_overflow;
        rsp_id   <= id_reg;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_reg [2];
  logic [1:0]  acc_vec;

  assign acc_vec = {req1_ready, req0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (acc_vec[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
        cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
      end
    end
  end

  assign grant_cnt0 = cnt_reg[0];
  assign grant_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the DUT's ALU port,
// a model predicts arbitration and responses, a negedge monitor compares.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctr;
  logic        alu_co, alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_co, rsp_zero, rsp_ovf;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
`endif
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctr      (alu_ctr),
    .alu_res      (alu_res),
    .alu_co       (alu_co),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_res      (rsp_res),
    .rsp_co       (rsp_co),
    .rsp_zero     (rsp_zero),
    .rsp_ovf      (rsp_ovf)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        zero;
    logic        ovf;
  } alu_out_t;

  typedef struct {
    logic     id;
    alu_out_t r;
    int       tick;
  } exp_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
    alu_out_t   r;
    logic [32:0] wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_AND:    r.res = a & b;
      OP_OR:     r.res = a | b;
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[31:0];
        r.co  = wide[32];
        r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      OP_PASS_A: r.res = a;
      OP_PASS_B: r.res = b;
      OP_NOR:    r.res = ~(a | b);
      OP_SUB: begin
        wide  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.res = wide[31:0];
        r.co  = wide[32];
        r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      default:   r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    r.zero = (r.res == 32'd0);
    return r;
  endfunction

  // Behavioural ALU sitting on the DUT's ALU port.
  alu_out_t alu_o;
  assign alu_o        = alu_ref(alu_a, alu_b, alu_ctr);
  assign alu_res      = alu_o.res;
  assign alu_co       = alu_o.co;
  assign alu_zero     = alu_o.zero;
  assign alu_overflow = alu_o.ovf;

  int   checks = 0;
  int   errors = 0;
  int   tick = 0;
  exp_t exp_q[$];
  logic model_last = 1'b1;
  int   outstanding = 0;
  bit   front_seen = 1'b0;
  int   model_cnt0 = 0, model_cnt1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: arbitration model plus response scoreboard.
  always @(negedge clk) begin : mon
    logic     e0, e1, id;
    exp_t     item;
    alu_out_t r;
    if (rst_n) begin
      tick++;
      e0 = (outstanding == 0) && req0_valid && (!req1_valid || model_last);
      e1 = (outstanding == 0) && req1_valid && (!req0_valid || !model_last);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        id = req1_valid && req1_ready;
        r  = id ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
        item.id   = id;
        item.r    = r;
        item.tick = tick;
        exp_q.push_back(item);
        $display("accept  id=%0d a=%08h b=%08h op=%0d", id, id ? req1_a : req0_a,
                 id ? req1_b : req0_b, id ? req1_op : req0_op);
        model_last = id;
        outstanding++;
        if (id) model_cnt1 = (model_cnt1 < 65535) ? model_cnt1 + 1 : 65535;
        else    model_cnt0 = (model_cnt0 < 65535) ? model_cnt0 + 1 : 65535;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          if (!front_seen) begin
            chk("rsp_latency", 64'(tick - exp_q[0].tick), 64'd2);
            front_seen = 1'b1;
          end
          chk("rsp_id", rsp_id, exp_q[0].id);
          chk("rsp_res", rsp_res, exp_q[0].r.res);
          chk("rsp_co", rsp_co, exp_q[0].r.co);
          chk("rsp_zero", rsp_zero, exp_q[0].r.zero);
          chk("rsp_ovf", rsp_ovf, exp_q[0].r.ovf);
          if (rsp_ready) begin
            $display("respond id=%0d res=%08h co=%0d z=%0d v=%0d", rsp_id, rsp_res,
                     rsp_co, rsp_zero, rsp_ovf);
            void'(exp_q.pop_front());
            outstanding--;
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, 1'b0);
    chk({tag, "_rsp_res"}, rsp_res, 32'd0);
    chk({tag, "_rsp_flags"}, {rsp_co, rsp_zero, rsp_ovf}, 3'b000);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_ctr"}, alu_ctr, 3'd0);
    chk({tag, "_readys"}, {req1_ready, req0_ready}, 2'b00);
`ifdef ALU_ARB_STATS_EN
    chk({tag, "_grant_cnt0"}, grant_cnt0, 16'd0);
    chk({tag, "_grant_cnt1"}, grant_cnt1, 16'd0);
`endif
  endtask

  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int n = 0;
    if (who) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    while (1) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) break;
      n++;
      if (n > 100) begin
        chk("issue_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outstanding != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("wait_idle_timeout", 64'(outstanding), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_model();
    exp_q.delete();
    outstanding = 0;
    model_last  = 1'b1;
    front_seen  = 1'b0;
    model_cnt0  = 0;
    model_cnt1  = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_release");

    // Contention straight from reset: grants alternate starting with req0.
    rsp_ready = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_op = OP_ADD;
    req1_a = 32'd7; req1_b = 32'd7; req1_op = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Single request, overflow and SLT.
    issue(1'b0, 32'd5, 32'd3, OP_ADD);
    wait_idle();
    issue(1'b0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    issue(1'b1, 32'd1, 32'd2, OP_SLT);
    wait_idle();

    // Backpressure: response held while req1 waits.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, OP_NOR);
    req1_a = 32'd100; req1_b = 32'd58; req1_op = OP_SUB; req1_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(1'b1, 32'd100, 32'd58, OP_SUB);
    wait_idle();

    // Reset during EXEC after a req0 grant; the next conflict must still go to req0.
    issue(1'b0, 32'hDEAD_BEEF, 32'd1, OP_ADD);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    clear_model();
    @(posedge clk); #1;
    req0_a = 32'd9; req0_b = 32'd4; req0_op = OP_SUB;
    req1_a = 32'd9; req1_b = 32'd4; req1_op = OP_OR;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Randomized traffic with random backpressure.
    repeat (700) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = pick_operand(); req0_b = pick_operand(); req0_op = 3'($urandom);
      req1_a = pick_operand(); req1_b = pick_operand(); req1_op = 3'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();

`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0_random", grant_cnt0, 16'(model_cnt0));
    chk("grant_cnt1_random", grant_cnt1, 16'(model_cnt1));
    rst_n = 1'b0;
    #1;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) issue(1'b0, 32'(i), 32'd1, OP_ADD);
    for (int i = 0; i < 3; i++) issue(1'b1, 32'(i), 32'd2, OP_OR);
    wait_idle();
    chk("grant_cnt0", grant_cnt0, 16'd5);
    chk("grant_cnt1", grant_cnt1, 16'd3);
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
